ysyx_25040111_lsu: RTL and testbench

//  Memory/write-back stage that consumes the EXU result handshake (exu_* side). It performs an

---
 rtl/ysyx_25040111_lsu.sv | 269 ++++++++++++++++++++++++++
 tb/tb_ysyx_25040111_lsu.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040111_lsu.sv
// ysyx_25040111_lsu: memory / write-back stage. It runs an optional single data-memory access,
// then writes the GPR/CSR files and retires with a one-cycle finish pulse.
// Optional build macro: YSYX_25040111_MISALIGN_TRAP_EN (trap misaligned half/word accesses).
module ysyx_25040111_lsu (
    input  logic        clock,
    input  logic        reset,
    input  logic        exu_valid,
    output logic        exu_ready,
    input  logic        exu_men,
    input  logic        exu_write,
    input  logic [31:0] exu_addr,
    input  logic [31:0] exu_wdata,
    input  logic [1:0]  exu_mask,
    input  logic        exu_rsign,
    input  logic [4:0]  exu_ard,
    input  logic [31:0] exu_rd,
    input  logic        exu_gen,
    input  logic [11:0] exu_acsr,
    input  logic [31:0] exu_csr,
    input  logic        exu_sen,
    input  logic [31:0] exu_pc,
    input  logic        erri,
    input  logic [3:0]  errtpi,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_write,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wstrb,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata,
    input  logic        mem_rsp_err,
    output logic        gpr_wen,
    output logic [4:0]  gpr_waddr,
    output logic [31:0] gpr_wdata,
    output logic        csr_wen,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic        finish,
    output logic [4:0]  frd,
    output logic        erro,
    output logic [3:0]  errtpo,
    output logic [31:0] erro_pc
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    localparam logic [3:0] CAUSE_LD_MIS   = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT = 4'd5;
    localparam logic [3:0] CAUSE_ST_MIS   = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT = 4'd7;

    function automatic logic [31:0] align_addr(input logic [31:0] a, input logic [1:0] m);
        case (m)
            2'b10:   align_addr = {a[31:1], 1'b0};
            2'b11:   align_addr = {a[31:2], 2'b00};
            default: align_addr = a;
        endcase
    endfunction

    function automatic logic [3:0] lane_strb(input logic [1:0] a, input logic [1:0] m);
        case (m)
            2'b10:   lane_strb = 4'b0011 << {a[1], 1'b0};
            2'b11:   lane_strb = 4'b1111;
            default: lane_strb = 4'b0001 << a;
        endcase
    endfunction

    function automatic logic [31:0] store_replicate(input logic [31:0] d, input logic [1:0] m);
        case (m)
            2'b10:   store_replicate = {2{d[15:0]}};
            2'b11:   store_replicate = d;
            default: store_replicate = {4{d[7:0]}};
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] d, input logic [1:0] a,
                                                 input logic [1:0] m, input logic s);
        logic [31:0] lane;
        lane = d >> {a, 3'b000};
        case (m)
            2'b10:   load_extract = {{16{s & lane[15]}}, lane[15:0]};
            2'b11:   load_extract = d;
            default: load_extract = {{24{s & lane[7]}}, lane[7:0]};
        endcase
    endfunction

`ifdef YSYX_25040111_MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [1:0] a, input logic [1:0] m);
        case (m)
            2'b10:   is_misaligned = a[0];
            2'b11:   is_misaligned = (a != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction
`endif

    state_t      r_state;
    state_t      w_next_state;
    logic        w_accept;
    logic        w_misalign;
    logic        w_acc_err;
    logic [3:0]  w_acc_cause;
    logic        w_in_req;
    logic        w_in_wb;
    logic        w_is_load;
    logic        w_is_store;

    logic        r_men;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_mask;
    logic        r_rsign;
    logic [4:0]  r_ard;
    logic [31:0] r_rd;
    logic        r_gen;
    logic [11:0] r_acsr;
    logic [31:0] r_csr;
    logic        r_sen;
    logic [31:0] r_pc;
    logic        r_err;
    logic [3:0]  r_errtp;
    logic [31:0] r_rdata;

    assign w_accept = exu_valid & (r_state == ST_IDLE);

`ifdef YSYX_25040111_MISALIGN_TRAP_EN
    assign w_misalign = exu_men & is_misaligned(exu_addr[1:0], exu_mask);
`else
    assign w_misalign = 1'b0;
`endif

    // Exception raised at accept time: upstream cause outranks a misaligned access
    always_comb begin
        w_acc_err   = 1'b0;
        w_acc_cause = 4'd0;
        if (erri) begin
            w_acc_err   = 1'b1;
            w_acc_cause = errtpi;
        end else if (w_misalign) begin
            w_acc_err   = 1'b1;
            w_acc_cause = exu_write ? CAUSE_ST_MIS : CAUSE_LD_MIS;
        end else begin
            w_acc_err   = 1'b0;
            w_acc_cause = 4'd0;
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; a faulted instruction skips the bus and goes straight to write-back
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (exu_men & ~w_acc_err) begin
                        w_next_state = ST_REQ;
                    end else begin
                        w_next_state = ST_WB;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    w_next_state = ST_RSP;
                end else begin
                    w_next_state = ST_REQ;
                end
            end
            ST_RSP: begin
                if (mem_rsp_valid) begin
                    w_next_state = ST_WB;
                end else begin
                    w_next_state = ST_RSP;
                end
            end
            ST_WB:   w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Capture the instruction on accept and the bus response when it arrives
    always_ff @(posedge clock) begin
        if (reset) begin
            r_men   <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_mask  <= 2'd0;
            r_rsign <= 1'b0;
            r_ard   <= 5'd0;
            r_rd    <= 32'd0;
            r_gen   <= 1'b0;
            r_acsr  <= 12'd0;
            r_csr   <= 32'd0;
            r_sen   <= 1'b0;
            r_pc    <= 32'd0;
            r_err   <= 1'b0;
            r_errtp <= 4'd0;
            r_rdata <= 32'd0;
        end else if (w_accept) begin
            r_men   <= exu_men;
            r_write <= exu_write;
            r_addr  <= align_addr(exu_addr, exu_mask);
            r_wdata <= exu_wdata;
            r_mask  <= exu_mask;
            r_rsign <= exu_rsign;
            r_ard   <= exu_ard;
            r_rd    <= exu_rd;
            r_gen   <= exu_gen;
            r_acsr  <= exu_acsr;
            r_csr   <= exu_csr;
            r_sen   <= exu_sen;
            r_pc    <= exu_pc;
            r_err   <= w_acc_err;
            r_errtp <= w_acc_cause;
        end else if ((r_state == ST_RSP) && mem_rsp_valid) begin
            r_rdata <= mem_rsp_rdata;
            if (mem_rsp_err) begin
                r_err   <= 1'b1;
                r_errtp <= r_write ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
            end
        end
    end

    assign w_in_req   = (r_state == ST_REQ);
    assign w_in_wb    = (r_state == ST_WB);
    assign w_is_load  = r_men & ~r_write;
    assign w_is_store = r_men & r_write;

    // Every output below is a decode of flops only, so nothing combinational reaches the ports
    assign exu_ready     = (r_state == ST_IDLE);
    assign mem_req_valid = w_in_req;
    assign mem_req_write = w_in_req & r_write;
    assign mem_req_addr  = w_in_req ? r_addr : 32'd0;
    assign mem_req_wdata = (w_in_req & r_write) ? store_replicate(r_wdata, r_mask) : 32'd0;
    assign mem_req_wstrb = (w_in_req & r_write) ? lane_strb(r_addr[1:0], r_mask) : 4'd0;

    assign finish    = w_in_wb;
    assign frd       = w_in_wb ? r_ard : 5'd0;
    assign gpr_wen   = w_in_wb & r_gen & ~r_err & (r_ard != 5'd0) & ~w_is_store;
    assign gpr_waddr = w_in_wb ? r_ard : 5'd0;
    assign gpr_wdata = w_in_wb ? (w_is_load ? load_extract(r_rdata, r_addr[1:0], r_mask, r_rsign)
                                            : r_rd)
                               : 32'd0;
    assign csr_wen   = w_in_wb & r_sen & ~r_err;
    assign csr_waddr = w_in_wb ? r_acsr : 12'd0;
    assign csr_wdata = w_in_wb ? r_csr : 32'd0;
    assign erro      = w_in_wb & r_err;
    assign errtpo    = (w_in_wb & r_err) ? r_errtp : 4'd0;
    assign erro_pc   = (w_in_wb & r_err) ? r_pc : 32'd0;

endmodule

// File: tb/tb_ysyx_25040111_lsu.sv
// Self-checking bench for ysyx_25040111_lsu: directed vector table, hand-written reset and
// misalign sequences, then random transactions checked against a byte-level reference model.
module tb_ysyx_25040111_lsu;

    logic        clock = 1'b0;
    logic        reset;
    logic        exu_valid, exu_ready, exu_men, exu_write, exu_rsign, exu_gen, exu_sen, erri;
    logic [31:0] exu_addr, exu_wdata, exu_rd, exu_csr, exu_pc;
    logic [1:0]  exu_mask;
    logic [4:0]  exu_ard;
    logic [11:0] exu_acsr;
    logic [3:0]  errtpi;
    logic        mem_req_valid, mem_req_ready, mem_req_write;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_rsp_valid, mem_rsp_err;
    logic [31:0] mem_rsp_rdata;
    logic        gpr_wen, csr_wen, finish, erro;
    logic [4:0]  gpr_waddr, frd;
    logic [31:0] gpr_wdata, csr_wdata, erro_pc;
    logic [11:0] csr_waddr;
    logic [3:0]  errtpo;

    ysyx_25040111_lsu dut (
        .clock(clock), .reset(reset),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_men(exu_men), .exu_write(exu_write),
        .exu_addr(exu_addr), .exu_wdata(exu_wdata), .exu_mask(exu_mask), .exu_rsign(exu_rsign),
        .exu_ard(exu_ard), .exu_rd(exu_rd), .exu_gen(exu_gen), .exu_acsr(exu_acsr),
        .exu_csr(exu_csr), .exu_sen(exu_sen), .exu_pc(exu_pc), .erri(erri), .errtpi(errtpi),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
        .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
        .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .finish(finish), .frd(frd), .erro(erro), .errtpo(errtpo), .erro_pc(erro_pc)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        men, write, rsign, gen, sen, erri, rsp_err;
        logic [31:0] addr, wdata, rd, csr, pc, rdata;
        logic [1:0]  mask;
        logic [4:0]  ard;
        logic [11:0] acsr;
        logic [3:0]  errtpi;
        int          delay;
    } txn_t;

    typedef struct {
        int          lat;
        logic        req, rwrite, stable, gwen, cwen, erro, one_pulse;
        logic [31:0] raddr, rwdata, gdata, cdata, epc;
        logic [3:0]  rstrb, errtp;
        logic [4:0]  gaddr, frd;
        logic [11:0] caddr;
    } obs_t;

    typedef struct {
        txn_t        t;
        int          e_lat;
        logic        e_gwen, e_erro;
        logic [31:0] e_gdata, e_wdata;
        logic [3:0]  e_errtp, e_strb;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic txn_t mk(input logic men, input logic write, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [1:0] mask,
                                input logic rsign, input logic [4:0] ard, input logic [31:0] rd,
                                input logic gen, input logic sen, input logic e_in,
                                input logic [3:0] etp, input logic [31:0] rdata,
                                input logic rsp_err, input int delay);
        txn_t t;
        t.men = men; t.write = write; t.addr = addr; t.wdata = wdata; t.mask = mask;
        t.rsign = rsign; t.ard = ard; t.rd = rd; t.gen = gen; t.sen = sen; t.erri = e_in;
        t.errtpi = etp; t.rdata = rdata; t.rsp_err = rsp_err; t.delay = delay;
        t.acsr = 12'h300; t.csr = 32'hC5C5_0001; t.pc = 32'h8000_0100 ^ addr;
        return t;
    endfunction

    // Reference model: works on byte counts and byte lanes, not on the DUT's encodings
    function automatic obs_t model(input txn_t t);
        obs_t        e;
        int          bytes;
        logic [31:0] ea, lv;
        logic        mis, err;
        logic [3:0]  cause;
        e = '{default: 0};
        bytes = (t.mask == 2'b11) ? 4 : (t.mask == 2'b10) ? 2 : 1;
        ea = t.addr - (t.addr % bytes);
`ifdef YSYX_25040111_MISALIGN_TRAP_EN
        mis = t.men && ((t.addr % bytes) != 0);
`else
        mis = 1'b0;
`endif
        err = t.erri;
        cause = t.errtpi;
        if (!err && mis) begin
            err = 1'b1;
            cause = t.write ? 4'd6 : 4'd4;
        end
        e.req = t.men && !err;
        if (e.req) begin
            e.raddr = ea;
            e.rwrite = t.write;
            if (t.write) begin
                e.rstrb = 4'(((1 << bytes) - 1) << (ea % 4));
                for (int i = 0; i < 4; i++) e.rwdata[8*i +: 8] = t.wdata[8*(i % bytes) +: 8];
            end
            if (t.rsp_err) begin
                err = 1'b1;
                cause = t.write ? 4'd7 : 4'd5;
            end
        end
        lv = t.rdata >> (8 * (ea % 4));
        if (bytes == 1) begin
            lv = lv & 32'h0000_00FF;
            if (t.rsign && lv[7]) lv = lv - 32'h0000_0100;
        end else if (bytes == 2) begin
            lv = lv & 32'h0000_FFFF;
            if (t.rsign && lv[15]) lv = lv - 32'h0001_0000;
        end
        e.lat = e.req ? 3 + t.delay : 1;
        e.stable = 1'b1;
        e.one_pulse = 1'b1;
        e.gwen = t.gen && !err && (t.ard != 5'd0) && !(t.men && t.write);
        e.gaddr = t.ard;
        e.gdata = (t.men && !t.write) ? lv : t.rd;
        e.cwen = t.sen && !err;
        e.caddr = t.acsr;
        e.cdata = t.csr;
        e.frd = t.ard;
        e.erro = err;
        e.errtp = cause;
        e.epc = t.pc;
        return e;
    endfunction

    // Drive one instruction, play the memory side, and record what the DUT did
    task automatic run_txn(input txn_t t, output obs_t o);
        int   stall;
        logic armed, done;
        o = '{default: 0};
        o.stable = 1'b1;
        o.lat = -1;
        @(negedge clock);
        chk("ready_before_accept", exu_ready, 1'b1);
        exu_men = t.men; exu_write = t.write; exu_addr = t.addr; exu_wdata = t.wdata;
        exu_mask = t.mask; exu_rsign = t.rsign; exu_ard = t.ard; exu_rd = t.rd;
        exu_gen = t.gen; exu_acsr = t.acsr; exu_csr = t.csr; exu_sen = t.sen;
        exu_pc = t.pc; erri = t.erri; errtpi = t.errtpi;
        exu_valid = 1'b1;
        @(posedge clock); #1;
        exu_valid = 1'b0;
        stall = t.delay;
        armed = 1'b0;
        done = 1'b0;
        for (int c = 1; c <= 40 && !done; c++) begin
            mem_rsp_valid = armed;
            mem_rsp_rdata = armed ? t.rdata : 32'd0;
            mem_rsp_err   = armed & t.rsp_err;
            armed = 1'b0;
            mem_req_ready = 1'b0;
            if (mem_req_valid) begin
                if (!o.req) begin
                    o.raddr = mem_req_addr; o.rwdata = mem_req_wdata;
                    o.rstrb = mem_req_wstrb; o.rwrite = mem_req_write;
                end else if (mem_req_addr !== o.raddr || mem_req_wdata !== o.rwdata ||
                             mem_req_wstrb !== o.rstrb || mem_req_write !== o.rwrite) begin
                    o.stable = 1'b0;
                end
                o.req = 1'b1;
                if (stall == 0) begin
                    mem_req_ready = 1'b1;
                    armed = 1'b1;
                end else begin
                    stall--;
                end
            end
            if (finish) begin
                o.lat = c; o.gwen = gpr_wen; o.gaddr = gpr_waddr; o.gdata = gpr_wdata;
                o.cwen = csr_wen; o.caddr = csr_waddr; o.cdata = csr_wdata; o.frd = frd;
                o.erro = erro; o.errtp = errtpo; o.epc = erro_pc;
                done = 1'b1;
            end
            @(posedge clock); #1;
        end
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b0;
        o.one_pulse = !finish && exu_ready;
    endtask

    task automatic compare(input string tag, input obs_t o, input obs_t e);
        chk({tag, ".latency"}, 32'(o.lat), 32'(e.lat));
        chk({tag, ".req"}, o.req, e.req);
        if (e.req) begin
            chk({tag, ".req_addr"}, o.raddr, e.raddr);
            chk({tag, ".req_write"}, o.rwrite, e.rwrite);
            chk({tag, ".req_stable"}, o.stable, 1'b1);
            if (e.rwrite) begin
                chk({tag, ".wstrb"}, o.rstrb, e.rstrb);
                chk({tag, ".wdata"}, o.rwdata, e.rwdata);
            end
        end
        chk({tag, ".frd"}, o.frd, e.frd);
        chk({tag, ".erro"}, o.erro, e.erro);
        if (e.erro) begin
            chk({tag, ".errtpo"}, o.errtp, e.errtp);
            chk({tag, ".erro_pc"}, o.epc, e.epc);
        end
        chk({tag, ".gpr_wen"}, o.gwen, e.gwen);
        if (e.gwen) begin
            chk({tag, ".gpr_waddr"}, o.gaddr, e.gaddr);
            chk({tag, ".gpr_wdata"}, o.gdata, e.gdata);
        end
        chk({tag, ".csr_wen"}, o.cwen, e.cwen);
        if (e.cwen) begin
            chk({tag, ".csr_waddr"}, o.caddr, e.caddr);
            chk({tag, ".csr_wdata"}, o.cdata, e.cdata);
        end
        chk({tag, ".single_pulse"}, o.one_pulse, 1'b1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[10];
        obs_t o;
        txn_t t;
        int   bad;

        vecs[0] = '{t: mk(1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 1'b0, 5'd5, 32'h1234, 1'b1, 1'b0,
                          1'b0, 4'd0, 32'h0, 1'b0, 0),
                    e_lat: 1, e_gwen: 1'b1, e_erro: 1'b0, e_gdata: 32'h0000_1234,
                    e_wdata: 32'h0, e_errtp: 4'd0, e_strb: 4'd0};
        vecs[1] = '{t: mk(1'b1, 1'b0, 32'h8000_0003, 32'h0, 2'b01, 1'b1, 5'd6, 32'h0, 1'b1, 1'b0,
                          1'b0, 4'd0, 32'h80FF_FF7F, 1'b0, 0),
                    e_lat: 3, e_gwen: 1'b1, e_erro: 1'b0, e_gdata: 32'hFFFF_FF80,
                    e_wdata: 32'h0, e_errtp: 4'd0, e_strb: 4'd0};
        vecs[2] = '{t: mk(1'b1, 1'b0, 32'h8000_0002, 32'h0, 2'b10, 1'b0, 5'd7, 32'h0, 1'b1, 1'b0,
                          1'b0, 4'd0, 32'hBEEF_1234, 1'b0, 1),
                    e_lat: 4, e_gwen: 1'b1, e_erro: 1'b0, e_gdata: 32'h0000_BEEF,
                    e_wdata: 32'h0, e_errtp: 4'd0, e_strb: 4'd0};
        vecs[3] = '{t: mk(1'b1, 1'b1, 32'h8000_0001, 32'h0000_00AB, 2'b01, 1'b0, 5'd8, 32'h0,
                          1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 3),
                    e_lat: 6, e_gwen: 1'b0, e_erro: 1'b0, e_gdata: 32'h0,
                    e_wdata: 32'hABAB_ABAB, e_errtp: 4'd0, e_strb: 4'b0010};
        vecs[4] = '{t: mk(1'b1, 1'b1, 32'h8000_0010, 32'h1122_3344, 2'b11, 1'b0, 5'd0, 32'h0,
                          1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 0),
                    e_lat: 3, e_gwen: 1'b0, e_erro: 1'b1, e_gdata: 32'h0,
                    e_wdata: 32'h1122_3344, e_errtp: 4'd7, e_strb: 4'hF};
        vecs[5] = '{t: mk(1'b1, 1'b0, 32'h8000_0014, 32'h0, 2'b11, 1'b0, 5'd9, 32'h0, 1'b1, 1'b1,
                          1'b0, 4'd0, 32'h5555_AAAA, 1'b1, 0),
                    e_lat: 3, e_gwen: 1'b0, e_erro: 1'b1, e_gdata: 32'h0,
                    e_wdata: 32'h0, e_errtp: 4'd5, e_strb: 4'd0};
        vecs[6] = '{t: mk(1'b1, 1'b0, 32'h8000_0020, 32'h0, 2'b11, 1'b0, 5'd10, 32'h0, 1'b1, 1'b1,
                          1'b1, 4'd2, 32'h0, 1'b0, 0),
                    e_lat: 1, e_gwen: 1'b0, e_erro: 1'b1, e_gdata: 32'h0,
                    e_wdata: 32'h0, e_errtp: 4'd2, e_strb: 4'd0};
        vecs[7] = '{t: mk(1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 1'b0, 5'd0, 32'h0000_FFFF, 1'b1, 1'b0,
                          1'b0, 4'd0, 32'h0, 1'b0, 0),
                    e_lat: 1, e_gwen: 1'b0, e_erro: 1'b0, e_gdata: 32'h0,
                    e_wdata: 32'h0, e_errtp: 4'd0, e_strb: 4'd0};
        vecs[8] = '{t: mk(1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 1'b0, 5'd11, 32'h0, 1'b0, 1'b1,
                          1'b0, 4'd0, 32'h0, 1'b0, 0),
                    e_lat: 1, e_gwen: 1'b0, e_erro: 1'b0, e_gdata: 32'h0,
                    e_wdata: 32'h0, e_errtp: 4'd0, e_strb: 4'd0};
        vecs[9] = '{t: mk(1'b1, 1'b1, 32'h8000_0002, 32'h0000_CAFE, 2'b10, 1'b0, 5'd12, 32'h0,
                          1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 0),
                    e_lat: 3, e_gwen: 1'b0, e_erro: 1'b0, e_gdata: 32'h0,
                    e_wdata: 32'hCAFE_CAFE, e_errtp: 4'd0, e_strb: 4'b1100};

        reset = 1'b1; exu_valid = 1'b0; exu_men = 1'b0; exu_write = 1'b0; exu_addr = 32'd0;
        exu_wdata = 32'd0; exu_mask = 2'd0; exu_rsign = 1'b0; exu_ard = 5'd0; exu_rd = 32'd0;
        exu_gen = 1'b0; exu_acsr = 12'd0; exu_csr = 32'd0; exu_sen = 1'b0; exu_pc = 32'd0;
        erri = 1'b0; errtpi = 4'd0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 32'd0; mem_rsp_err = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("reset.exu_ready", exu_ready, 1'b1);
        chk("reset.finish", finish, 1'b0);
        chk("reset.mem_req_valid", mem_req_valid, 1'b0);
        chk("reset.gpr_wen", gpr_wen, 1'b0);
        chk("reset.erro", erro, 1'b0);

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].t, o);
            chk($sformatf("vec%0d.latency", i), 32'(o.lat), 32'(vecs[i].e_lat));
            chk($sformatf("vec%0d.gpr_wen", i), o.gwen, vecs[i].e_gwen);
            if (vecs[i].e_gwen) chk($sformatf("vec%0d.gpr_wdata", i), o.gdata, vecs[i].e_gdata);
            chk($sformatf("vec%0d.erro", i), o.erro, vecs[i].e_erro);
            if (vecs[i].e_erro) chk($sformatf("vec%0d.errtpo", i), o.errtp, vecs[i].e_errtp);
            if (vecs[i].t.men && vecs[i].t.write) begin
                chk($sformatf("vec%0d.wstrb", i), o.rstrb, vecs[i].e_strb);
                chk($sformatf("vec%0d.wdata", i), o.rwdata, vecs[i].e_wdata);
                chk($sformatf("vec%0d.stable", i), o.stable, 1'b1);
            end
            compare($sformatf("vec%0d", i), o, model(vecs[i].t));
        end

        // Misaligned word load and half store: trapped, or forced to the aligned address
        t = mk(1'b1, 1'b0, 32'h8000_0042, 32'h0, 2'b11, 1'b0, 5'd13, 32'h0, 1'b1, 1'b0,
               1'b0, 4'd0, 32'h0102_0304, 1'b0, 0);
        run_txn(t, o);
`ifdef YSYX_25040111_MISALIGN_TRAP_EN
        chk("mis_lw.no_req", o.req, 1'b0);
        chk("mis_lw.errtpo", o.errtp, 4'd4);
        chk("mis_lw.gpr_wen", o.gwen, 1'b0);
`else
        chk("mis_lw.forced_addr", o.raddr, 32'h8000_0040);
        chk("mis_lw.gpr_wdata", o.gdata, 32'h0102_0304);
`endif
        compare("mis_lw", o, model(t));
        t = mk(1'b1, 1'b1, 32'h8000_0047, 32'h0000_BEAD, 2'b10, 1'b0, 5'd14, 32'h0, 1'b0, 1'b0,
               1'b0, 4'd0, 32'h0, 1'b0, 0);
        run_txn(t, o);
        compare("mis_sh", o, model(t));

        // Reset while waiting for the response, then a stray response in IDLE
        @(negedge clock);
        exu_men = 1'b1; exu_write = 1'b0; exu_addr = 32'h8000_0020; exu_mask = 2'b11;
        exu_gen = 1'b1; exu_ard = 5'd10; exu_sen = 1'b1; erri = 1'b0; exu_valid = 1'b1;
        @(posedge clock); #1;
        exu_valid = 1'b0;
        chk("rst_mid.req_issued", mem_req_valid, 1'b1);
        mem_req_ready = 1'b1;
        @(posedge clock); #1;
        mem_req_ready = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("rst_mid.exu_ready_after", exu_ready, 1'b1);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hDEAD_BEEF;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            if (gpr_wen || finish || csr_wen || mem_req_valid) bad++;
            @(posedge clock); #1;
        end
        mem_rsp_valid = 1'b0;
        chk("rst_mid.no_retire", 32'(bad), 32'd0);
        chk("rst_mid.idle", exu_ready, 1'b1);

        // Random instructions against the reference model
        for (int n = 0; n < 60; n++) begin
            t = mk(1'($urandom), 1'($urandom), 32'h8000_0000 | ($urandom & 32'h0000_00FF),
                   $urandom, 2'($urandom_range(1, 3)), 1'($urandom), 5'($urandom), $urandom,
                   1'($urandom), 1'($urandom), ($urandom % 8) == 0, 4'($urandom),
                   $urandom, ($urandom % 6) == 0, int'($urandom % 3));
            run_txn(t, o);
            compare($sformatf("rnd%0d", n), o, model(t));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
